// File: rtl/tv80_pkg.sv
// Shared TV80 definitions: flag bit positions, ALU_Op codes, 16-bit op codes,
// and the state encoding of the 16-bit arithmetic sequencer.
package tv80_pkg;

  localparam int OP_W = 2;

  localparam int FLAG_C = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_X = 3;
  localparam int FLAG_H = 4;
  localparam int FLAG_Y = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 7;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;

  typedef enum logic [OP_W-1:0] {
    OP16_ADD = 2'b00,
    OP16_ADC = 2'b01,
    OP16_SBC = 2'b10
  } op16_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10,
    ST_DONE = 2'b11
  } seq_state_e;

  // The low pass of ADD HL,rr has no carry in; the high pass always chains it.
  function automatic logic [3:0] lo_alu_op(input op16_e op);
    case (op)
      OP16_ADC: lo_alu_op = ALU_ADC;
      OP16_SBC: lo_alu_op = ALU_SBC;
      default:  lo_alu_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] hi_alu_op(input op16_e op);
    case (op)
      OP16_SBC: hi_alu_op = ALU_SBC;
      default:  hi_alu_op = ALU_ADC;
    endcase
  endfunction

endpackage

// File: rtl/tv80_alu16_seq.sv
// Runs ADD/ADC/SBC HL,rr through the external TV80 8-bit ALU as a low-byte
// pass followed by a high-byte pass, then reports the 16-bit result and flags.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; ALU drive at rest values
// LO      | ALU computes the low byte from the issue flags
// HI      | ALU computes the high byte, chained on the low-byte flags
// DONE    | one-cycle done pulse; result/f_result valid and held
module tv80_alu16_seq
  import tv80_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [15:0]     a_in,
  input  logic [15:0]     b_in,
  input  logic [7:0]      f_in,
  output logic            busy,
  output logic            done,
  output logic [15:0]     result,
  output logic [7:0]      f_result,
  output logic [3:0]      alu_op,
  output logic [7:0]      alu_bus_a,
  output logic [7:0]      alu_bus_b,
  output logic            alu_arith16,
  output logic            alu_z16,
  output logic [7:0]      alu_f_in,
  input  logic [7:0]      alu_q,
  input  logic [7:0]      alu_f_out
);

  seq_state_e r_state;
  op16_e      r_op;
  logic [7:0] r_a_hi;
  logic [7:0] r_b_hi;
  logic [7:0] r_q_lo;
  logic       r_busy;
  logic       r_done;
  logic [15:0] r_result;
  logic [7:0] r_f_result;
  logic [3:0] r_alu_op;
  logic [7:0] r_alu_bus_a;
  logic [7:0] r_alu_bus_b;
  logic       r_alu_arith16;
  logic       r_alu_z16;
  logic [7:0] r_alu_f_in;

  op16_e w_op_map;

  assign w_op_map = (op == 2'b11) ? OP16_ADD : op16_e'(op);

  // The low-byte drive is registered straight from the issue inputs, so those
  // registers double as the latched low operand bytes and issue flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_op          <= OP16_ADD;
      r_a_hi        <= 8'h00;
      r_b_hi        <= 8'h00;
      r_q_lo        <= 8'h00;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= 16'h0000;
      r_f_result    <= 8'h00;
      r_alu_op      <= ALU_ADD;
      r_alu_bus_a   <= 8'h00;
      r_alu_bus_b   <= 8'h00;
      r_alu_arith16 <= 1'b0;
      r_alu_z16     <= 1'b0;
      r_alu_f_in    <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op          <= w_op_map;
            r_a_hi        <= a_in[15:8];
            r_b_hi        <= b_in[15:8];
            r_busy        <= 1'b1;
            r_alu_op      <= lo_alu_op(w_op_map);
            r_alu_bus_a   <= a_in[7:0];
            r_alu_bus_b   <= b_in[7:0];
            r_alu_f_in    <= f_in;
            r_alu_arith16 <= (w_op_map == OP16_ADD);
            r_alu_z16     <= 1'b0;
            r_state       <= ST_LO;
          end
        end
        ST_LO: begin
          r_q_lo        <= alu_q;
          r_alu_f_in    <= alu_f_out;
          r_alu_op      <= hi_alu_op(r_op);
          r_alu_bus_a   <= r_a_hi;
          r_alu_bus_b   <= r_b_hi;
          r_alu_arith16 <= (r_op == OP16_ADD);
          r_alu_z16     <= (r_op != OP16_ADD);
          r_state       <= ST_HI;
        end
        ST_HI: begin
          r_result      <= {alu_q, r_q_lo};
          r_f_result    <= alu_f_out;
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
          r_alu_op      <= ALU_ADD;
          r_alu_bus_a   <= 8'h00;
          r_alu_bus_b   <= 8'h00;
          r_alu_arith16 <= 1'b0;
          r_alu_z16     <= 1'b0;
          r_alu_f_in    <= 8'h00;
          r_state       <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign f_result    = r_f_result;
  assign alu_op      = r_alu_op;
  assign alu_bus_a   = r_alu_bus_a;
  assign alu_bus_b   = r_alu_bus_b;
  assign alu_arith16 = r_alu_arith16;
  assign alu_z16     = r_alu_z16;
  assign alu_f_in    = r_alu_f_in;

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq paired with a behavioural TV80 ALU (add/sub group
// only); directed vectors with hand-computed results and flags.
module tb_tv80_alu16_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [7:0]  f_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [7:0]  f_result;
  logic [3:0]  alu_op;
  logic [7:0]  alu_bus_a;
  logic [7:0]  alu_bus_b;
  logic        alu_arith16;
  logic        alu_z16;
  logic [7:0]  alu_f_in;
  logic [7:0]  alu_q;
  logic [7:0]  alu_f_out;

  int n_checks = 0;
  int n_errors = 0;

  tv80_alu16_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .f_in        (f_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .f_result    (f_result),
    .alu_op      (alu_op),
    .alu_bus_a   (alu_bus_a),
    .alu_bus_b   (alu_bus_b),
    .alu_arith16 (alu_arith16),
    .alu_z16     (alu_z16),
    .alu_f_in    (alu_f_in),
    .alu_q       (alu_q),
    .alu_f_out   (alu_f_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural TV80 ALU for ALU_Op 0..3 (ADD/ADC/SUB/SBC).
  logic       m_sub;
  logic       m_cin;
  logic [7:0] m_bb;
  logic [4:0] m_s4;
  logic [7:0] m_s7;
  logic [8:0] m_s8;

  always_comb begin
    m_sub = alu_op[1];
    m_cin = (alu_op[0] & ~alu_op[2] & alu_f_in[0]) ^ m_sub;
    m_bb  = m_sub ? ~alu_bus_b : alu_bus_b;
    m_s4  = {1'b0, alu_bus_a[3:0]} + {1'b0, m_bb[3:0]} + {4'b0, m_cin};
    m_s7  = {1'b0, alu_bus_a[6:0]} + {1'b0, m_bb[6:0]} + {7'b0, m_cin};
    m_s8  = {1'b0, alu_bus_a} + {1'b0, m_bb} + {8'b0, m_cin};
    alu_q = m_s8[7:0];
    alu_f_out    = alu_f_in;
    alu_f_out[0] = m_s8[8] ^ m_sub;
    alu_f_out[1] = m_sub;
    alu_f_out[2] = m_s7[7] ^ m_s8[8];
    alu_f_out[3] = m_s8[3];
    alu_f_out[4] = m_s4[4] ^ m_sub;
    alu_f_out[5] = m_s8[5];
    alu_f_out[6] = (m_s8[7:0] == 8'h00) ? (alu_z16 ? alu_f_in[6] : 1'b1) : 1'b0;
    alu_f_out[7] = m_s8[7];
    if (alu_arith16) begin
      alu_f_out[7] = alu_f_in[7];
      alu_f_out[6] = alu_f_in[6];
      alu_f_out[2] = alu_f_in[2];
    end
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op and checks both passes, the done cycle and the hold cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [7:0] f,
                        input logic [15:0] exp_r, input logic [7:0] exp_f,
                        input logic [3:0] exp_lo_op, input logic [3:0] exp_hi_op,
                        input logic exp_a16, input logic exp_z16);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b; f_in = f;
    @(negedge clk);
    start = 1'b0; op = ~o; a_in = ~a; b_in = 16'h5A5A; f_in = ~f;
    check_val({tag, " lo busy"},    16'(busy),        16'd1);
    check_val({tag, " lo done"},    16'(done),        16'd0);
    check_val({tag, " lo alu_op"},  16'(alu_op),      16'(exp_lo_op));
    check_val({tag, " lo bus_a"},   16'(alu_bus_a),   16'(a[7:0]));
    check_val({tag, " lo bus_b"},   16'(alu_bus_b),   16'(b[7:0]));
    check_val({tag, " lo f_in"},    16'(alu_f_in),    16'(f));
    check_val({tag, " lo arith16"}, 16'(alu_arith16), 16'(exp_a16));
    check_val({tag, " lo z16"},     16'(alu_z16),     16'd0);
    @(negedge clk);
    check_val({tag, " hi alu_op"},  16'(alu_op),      16'(exp_hi_op));
    check_val({tag, " hi bus_a"},   16'(alu_bus_a),   16'(a[15:8]));
    check_val({tag, " hi bus_b"},   16'(alu_bus_b),   16'(b[15:8]));
    check_val({tag, " hi arith16"}, 16'(alu_arith16), 16'(exp_a16));
    check_val({tag, " hi z16"},     16'(alu_z16),     16'(exp_z16));
    check_val({tag, " hi done"},    16'(done),        16'd0);
    @(negedge clk);
    check_val({tag, " done"},       16'(done),        16'd1);
    check_val({tag, " done busy"},  16'(busy),        16'd0);
    check_val({tag, " result"},     result,           exp_r);
    check_val({tag, " f_result"},   16'(f_result),    16'(exp_f));
    check_val({tag, " rest alu_op"}, 16'(alu_op),     16'd0);
    check_val({tag, " rest f_in"},  16'(alu_f_in),    16'd0);
    @(negedge clk);
    check_val({tag, " done pulse"}, 16'(done),        16'd0);
    check_val({tag, " hold"},       result,           exp_r);
  endtask

  logic [15:0] done_mask;
  int          done_cnt;

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00;
    a_in = 16'h0; b_in = 16'h0; f_in = 8'h0;
    repeat (2) @(negedge clk);
    check_val("rst busy",     16'(busy),        16'd0);
    check_val("rst done",     16'(done),        16'd0);
    check_val("rst result",   result,           16'h0000);
    check_val("rst f_result", 16'(f_result),    16'd0);
    check_val("rst alu_op",   16'(alu_op),      16'd0);
    check_val("rst bus_a",    16'(alu_bus_a),   16'd0);
    check_val("rst bus_b",    16'(alu_bus_b),   16'd0);
    check_val("rst arith16",  16'(alu_arith16), 16'd0);
    check_val("rst z16",      16'(alu_z16),     16'd0);
    check_val("rst f_in",     16'(alu_f_in),    16'd0);
    reset_n = 1'b1;

    //     tag        op     a         b         f      result    flags  lo_op  hi_op  a16   z16
    run_op("add",     2'b00, 16'h1234, 16'h0FFF, 8'h00, 16'h2233, 8'h30, 4'h0,  4'h1,  1'b1, 1'b0);
    run_op("adc",     2'b01, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h51, 4'h1,  4'h1,  1'b0, 1'b1);
    run_op("sbc",     2'b10, 16'h1000, 16'h0001, 8'h00, 16'h0FFF, 8'h1A, 4'h3,  4'h3,  1'b0, 1'b1);
    run_op("sbc_z0",  2'b10, 16'h0100, 16'h00FF, 8'h00, 16'h0001, 8'h02, 4'h3,  4'h3,  1'b0, 1'b1);
    run_op("sbc_z1",  2'b10, 16'h0100, 16'h0100, 8'h00, 16'h0000, 8'h42, 4'h3,  4'h3,  1'b0, 1'b1);
    run_op("add_kp",  2'b00, 16'h0001, 16'h0001, 8'hC4, 16'h0002, 8'hC4, 4'h0,  4'h1,  1'b1, 1'b0);
    run_op("op11",    2'b11, 16'h0001, 16'h0001, 8'h00, 16'h0002, 8'h00, 4'h0,  4'h1,  1'b1, 1'b0);

    // start held for 5 cycles: accepted at the first edge and again once back in IDLE
    @(negedge clk);
    start = 1'b1; op = 2'b00; a_in = 16'h1234; b_in = 16'h0FFF; f_in = 8'h00;
    done_mask = 16'h0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 4) start = 1'b0;
      done_mask[k] = done;
    end
    check_val("hold start done mask", done_mask, 16'h0044);
    check_val("hold start result", result, 16'h2233);

    // reset during HI
    @(negedge clk);
    start = 1'b1; op = 2'b10; a_in = 16'h1000; b_in = 16'h0001; f_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("pre-rst in hi", 16'(alu_op), 16'h3);
    #1 reset_n = 1'b0;
    #1;
    check_val("mid rst busy",    16'(busy),      16'd0);
    check_val("mid rst done",    16'(done),      16'd0);
    check_val("mid rst alu_op",  16'(alu_op),    16'd0);
    check_val("mid rst bus_a",   16'(alu_bus_a), 16'd0);
    check_val("mid rst z16",     16'(alu_z16),   16'd0);
    check_val("mid rst f_in",    16'(alu_f_in),  16'd0);
    check_val("mid rst result",  result,         16'h0000);
    check_val("mid rst f_res",   16'(f_result),  16'd0);
    #1 reset_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("no done after rst", 16'(done_cnt), 16'd0);
    check_val("idle after rst busy", 16'(busy), 16'd0);

    run_op("post_rst", 2'b10, 16'h1000, 16'h0001, 8'h00, 16'h0FFF, 8'h1A, 4'h3, 4'h3, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
